// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and state encoding for the fetch PC unit.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_SIZE_DEF  = 32'h0000_4000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_addr_check.sv
// Combinational fetch address check: misalignment or outside the instruction window.
module fetch_pc_unit_addr_check
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_SIZE = IM_SIZE_DEF
) (
  input  logic [31:0] pc,
  output logic        fault,
  output logic [4:0]  exccode
);

  // 33-bit limit so a window ending at 4 GiB does not wrap to zero
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  always_comb begin
    fault   = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
    exccode = fault ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: architectural PC register, IF/ID pipeline register and fetch-fault FSM.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_SIZE  = IM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        id_is_ctrl,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_bd,
  output logic        if_id_exc,
  output logic [4:0]  if_id_exccode
);

  // state    | meaning
  // ST_RUN   | fetching; pc advances to npc on each non-stalled edge
  // ST_FAULT | faulting fetch latched in IF/ID; pc frozen until exc_req or eret

  fetch_state_t state;
  logic         fault;
  logic [4:0]   fault_code;

  fetch_pc_unit_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_SIZE (IM_SIZE)
  ) u_addr_check (
    .pc      (pc),
    .fault   (fault),
    .exccode (fault_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pc            <= RESET_PC;
      if_id_instr   <= 32'h0;
      if_id_pc      <= 32'h0;
      if_id_valid   <= 1'b0;
      if_id_bd      <= 1'b0;
      if_id_exc     <= 1'b0;
      if_id_exccode <= EXC_NONE;
    end else if (exc_req || eret) begin
      state         <= ST_RUN;
      pc            <= exc_req ? EXC_VEC : epc;
      if_id_instr   <= 32'h0;
      if_id_valid   <= 1'b0;
      if_id_bd      <= 1'b0;
      if_id_exc     <= 1'b0;
      if_id_exccode <= EXC_NONE;
    end else if (!stall && state == ST_RUN) begin
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
      if_id_bd    <= id_is_ctrl;
      if (fault) begin
        // faulting fetch becomes a nop carrying AdEL; pc stays on the bad address
        state         <= ST_FAULT;
        if_id_instr   <= 32'h0;
        if_id_exc     <= 1'b1;
        if_id_exccode <= fault_code;
      end else begin
        pc            <= npc;
        if_id_instr   <= instr;
        if_id_exc     <= 1'b0;
        if_id_exccode <= EXC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc, instr, epc;
  logic        stall, exc_req, eret, id_is_ctrl;
  logic [31:0] pc, if_id_instr, if_id_pc;
  logic        if_id_valid, if_id_bd, if_id_exc;
  logic [4:0]  if_id_exccode;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .npc           (npc),
    .instr         (instr),
    .stall         (stall),
    .exc_req       (exc_req),
    .eret          (eret),
    .epc           (epc),
    .id_is_ctrl    (id_is_ctrl),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .if_id_bd      (if_id_bd),
    .if_id_exc     (if_id_exc),
    .if_id_exccode (if_id_exccode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc = 32'h3004; instr = 32'hAAAA_0001; epc = 32'h0;
    stall = 1'b0; exc_req = 1'b0; eret = 1'b0; id_is_ctrl = 1'b0;
    step(); step();
    n_cmp++; if (pc !== 32'h3000) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    n_cmp++; if ({if_id_instr, if_id_pc, if_id_bd, if_id_exc, if_id_exccode} !== 71'h0) begin
      n_err++; $display("FAIL reset_ifid got instr=%h pc=%h bd=%b exc=%b code=%0d exp all 0",
                        if_id_instr, if_id_pc, if_id_bd, if_id_exc, if_id_exccode); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (pc !== 32'h3004) begin n_err++; $display("FAIL first_pc got %h exp 3004", pc); end
    n_cmp++; if (if_id_pc !== 32'h3000 || if_id_valid !== 1'b1 || if_id_instr !== 32'hAAAA_0001) begin
      n_err++; $display("FAIL first_ifid got pc=%h v=%b instr=%h exp 3000 1 aaaa0001", if_id_pc, if_id_valid, if_id_instr); end
  endtask

  task automatic test_stall();
    npc = 32'h3008; instr = 32'hBBBB_0002;
    step();
    npc = 32'h3010; instr = 32'hCCCC_0003; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pc !== 32'h3008 || if_id_pc !== 32'h3004 || if_id_instr !== 32'hBBBB_0002 || if_id_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d] got pc=%h ifpc=%h instr=%h v=%b exp 3008 3004 bbbb0002 1",
                          i, pc, if_id_pc, if_id_instr, if_id_valid); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h3010 || if_id_pc !== 32'h3008 || if_id_instr !== 32'hCCCC_0003) begin
      n_err++; $display("FAIL stall_release got pc=%h ifpc=%h instr=%h exp 3010 3008 cccc0003", pc, if_id_pc, if_id_instr); end
  endtask

  task automatic test_delay_slot();
    id_is_ctrl = 1'b1; npc = 32'h3014;
    step();
    n_cmp++; if (if_id_bd !== 1'b1 || if_id_pc !== 32'h3010 || pc !== 32'h3014) begin
      n_err++; $display("FAIL bd_set got bd=%b ifpc=%h pc=%h exp 1 3010 3014", if_id_bd, if_id_pc, pc); end
    id_is_ctrl = 1'b0; stall = 1'b1;
    step();
    n_cmp++; if (if_id_bd !== 1'b1) begin n_err++; $display("FAIL bd_stall_keep1 got %b exp 1", if_id_bd); end
    stall = 1'b0; npc = 32'h3018;
    step();
    n_cmp++; if (if_id_bd !== 1'b0 || pc !== 32'h3018) begin
      n_err++; $display("FAIL bd_clear got bd=%b pc=%h exp 0 3018", if_id_bd, pc); end
    id_is_ctrl = 1'b1; stall = 1'b1;
    step();
    n_cmp++; if (if_id_bd !== 1'b0 || pc !== 32'h3018) begin
      n_err++; $display("FAIL bd_stall_keep0 got bd=%b pc=%h exp 0 3018", if_id_bd, pc); end
    id_is_ctrl = 1'b0; stall = 1'b0;
  endtask

  task automatic test_exc_eret();
    stall = 1'b1; exc_req = 1'b1; npc = 32'h3100;
    step();
    n_cmp++; if (pc !== 32'h4180 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_err++; $display("FAIL exc_over_stall got pc=%h v=%b instr=%h exp 4180 0 0", pc, if_id_valid, if_id_instr); end
    stall = 1'b0; exc_req = 1'b0; eret = 1'b1; epc = 32'h3020;
    step();
    n_cmp++; if (pc !== 32'h3020 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL eret got pc=%h v=%b exp 3020 0", pc, if_id_valid); end
    exc_req = 1'b1; epc = 32'h3040;
    step();
    n_cmp++; if (pc !== 32'h4180) begin n_err++; $display("FAIL exc_beats_eret got pc=%h exp 4180", pc); end
    exc_req = 1'b0; epc = 32'h3020;
    step();
    eret = 1'b0;
  endtask

  task automatic test_misaligned();
    npc = 32'h3002; instr = 32'hDDDD_0004;
    step();
    n_cmp++; if (pc !== 32'h3002 || if_id_pc !== 32'h3020 || if_id_exc !== 1'b0) begin
      n_err++; $display("FAIL mis_enter got pc=%h ifpc=%h exc=%b exp 3002 3020 0", pc, if_id_pc, if_id_exc); end
    npc = 32'h3006;
    step();
    n_cmp++; if (if_id_instr !== 32'h0 || if_id_exc !== 1'b1 || if_id_exccode !== 5'd4 || if_id_pc !== 32'h3002
                 || if_id_valid !== 1'b1 || pc !== 32'h3002) begin
      n_err++; $display("FAIL mis_latch got instr=%h exc=%b code=%0d ifpc=%h v=%b pc=%h exp 0 1 4 3002 1 3002",
                        if_id_instr, if_id_exc, if_id_exccode, if_id_pc, if_id_valid, pc); end
    npc = 32'h3200;
    step(); step();
    n_cmp++; if (pc !== 32'h3002 || if_id_exc !== 1'b1 || if_id_pc !== 32'h3002) begin
      n_err++; $display("FAIL fault_hold got pc=%h exc=%b ifpc=%h exp 3002 1 3002", pc, if_id_exc, if_id_pc); end
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    n_cmp++; if (pc !== 32'h4180 || if_id_exc !== 1'b0 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL fault_exit got pc=%h exc=%b v=%b exp 4180 0 0", pc, if_id_exc, if_id_valid); end
    npc = 32'h4184;
    step();
    n_cmp++; if (pc !== 32'h4184 || if_id_pc !== 32'h4180 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL run_after_fault got pc=%h ifpc=%h v=%b exp 4184 4180 1", pc, if_id_pc, if_id_valid); end
  endtask

  // jump via eret to addr, then one normal edge to latch the fetch there
  task automatic range_probe(input logic [31:0] addr, input logic exp_exc);
    eret = 1'b1; epc = addr;
    step();
    eret = 1'b0; npc = addr + 32'h4; instr = 32'hEEEE_0005;
    step();
    n_cmp++; if (if_id_exc !== exp_exc || if_id_exccode !== (exp_exc ? 5'd4 : 5'd0) || if_id_pc !== addr
                 || if_id_instr !== (exp_exc ? 32'h0 : 32'hEEEE_0005)
                 || pc !== (exp_exc ? addr : addr + 32'h4)) begin
      n_err++; $display("FAIL range_%h got exc=%b code=%0d ifpc=%h instr=%h pc=%h exp exc=%b",
                        addr, if_id_exc, if_id_exccode, if_id_pc, if_id_instr, pc, exp_exc); end
  endtask

  task automatic test_range();
    range_probe(32'h2FFC, 1'b1);
    range_probe(32'h7000, 1'b1);
    range_probe(32'h6FFC, 1'b0);
    range_probe(32'h3000, 1'b0);
    range_probe(32'hFFFF_FFFC, 1'b1);
  endtask

  task automatic test_reset_in_fault();
    range_probe(32'h7000, 1'b1);
    rst_n = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h3000 || if_id_exc !== 1'b0 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_fault got pc=%h exc=%b v=%b exp 3000 0 0", pc, if_id_exc, if_id_valid); end
    rst_n = 1'b1; npc = 32'h3004; instr = 32'h1234_5678;
    step();
    n_cmp++; if (pc !== 32'h3004 || if_id_pc !== 32'h3000 || if_id_valid !== 1'b1 || if_id_instr !== 32'h1234_5678) begin
      n_err++; $display("FAIL reset_fault_run got pc=%h ifpc=%h v=%b instr=%h exp 3004 3000 1 12345678",
                        pc, if_id_pc, if_id_valid, if_id_instr); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_delay_slot();
    test_exc_eret();
    test_misaligned();
    test_range();
    test_reset_in_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
